// File: rtl/heartbeat_window_monitor.sv
// Heartbeat qualifier: measures rising-edge-to-rising-edge period of an async
// pwm line, windows each period and drives a hysteretic alive/dead FSM.
module heartbeat_window_monitor #(
    parameter int CNT_W      = 24,
    parameter int MIN_PERIOD = 40000,
    parameter int MAX_PERIOD = 60000,
    parameter int GOOD_N     = 4,
    parameter int BAD_N      = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwm,
    input  logic             enable,
    output logic             io,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             fault,
    output logic [1:0]       fault_code
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ACQUIRE = 2'd1;
    localparam logic [1:0] ST_ALIVE   = 2'd2;
    localparam logic [1:0] ST_SUSPECT = 2'd3;

    localparam int GW = $clog2(GOOD_N + 1);
    localparam int BW = $clog2(BAD_N + 1);

    localparam logic [CNT_W-1:0] MIN_C   = CNT_W'(MIN_PERIOD);
    localparam logic [CNT_W-1:0] MAX_C   = CNT_W'(MAX_PERIOD);
    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(MAX_PERIOD + 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [GW-1:0]    GOOD_C  = GW'(GOOD_N);
    localparam logic [BW-1:0]    BAD_C   = BW'(BAD_N);

    logic             sync1_reg, sync2_reg, sync_d_reg, edge_reg;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             armed_reg, armed_next;
    logic [GW-1:0]    good_cnt_reg, good_cnt_next, good_inc;
    logic [BW-1:0]    bad_cnt_reg, bad_cnt_next, bad_inc;
    logic [1:0]       state_reg, state_next;
    logic [CNT_W-1:0] period_reg, period_next;
    logic             period_valid_reg, period_valid_next;
    logic             fault_reg, fault_next;
    logic [1:0]       fault_code_reg, fault_code_next;
    logic             measure, timeout, is_short, is_long, is_good, is_bad;

    // Input path keeps running regardless of enable so no edge is half-seen.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_reg  <= 1'b0;
            sync2_reg  <= 1'b0;
            sync_d_reg <= 1'b0;
            edge_reg   <= 1'b0;
        end else begin
            sync1_reg  <= pwm;
            sync2_reg  <= sync1_reg;
            sync_d_reg <= sync2_reg;
            edge_reg   <= sync2_reg & ~sync_d_reg;
        end
    end

    always_comb begin
        measure  = edge_reg && armed_reg;
        // An edge coinciding with saturation is measured instead of timing out.
        timeout  = armed_reg && !edge_reg && (cnt_reg == CNT_SAT);
        is_short = measure && (cnt_reg < MIN_C);
        is_long  = measure && (cnt_reg > MAX_C);
        is_good  = measure && !is_short && !is_long;
        is_bad   = is_short || is_long || timeout;
        good_inc = good_cnt_reg + 1'b1;
        bad_inc  = bad_cnt_reg + 1'b1;

        if (edge_reg)                 cnt_next = CNT_ONE;
        else if (cnt_reg == CNT_SAT)  cnt_next = cnt_reg;
        else                          cnt_next = cnt_reg + 1'b1;

        if (edge_reg)      armed_next = 1'b1;
        else if (timeout)  armed_next = 1'b0;
        else               armed_next = armed_reg;

        state_next    = state_reg;
        good_cnt_next = good_cnt_reg;
        bad_cnt_next  = bad_cnt_reg;

        case (state_reg)
            ST_IDLE: begin
                if (edge_reg) begin
                    state_next    = ST_ACQUIRE;
                    good_cnt_next = '0;
                end
            end
            ST_ACQUIRE: begin
                if (is_good) begin
                    if (good_inc == GOOD_C) begin
                        state_next    = ST_ALIVE;
                        good_cnt_next = '0;
                        bad_cnt_next  = '0;
                    end else begin
                        good_cnt_next = good_inc;
                    end
                end else if (is_short) begin
                    good_cnt_next = '0;
                end else if (is_bad) begin
                    state_next    = ST_IDLE;
                    good_cnt_next = '0;
                end
            end
            ST_ALIVE: begin
                if (is_bad) begin
                    bad_cnt_next = BW'(1);
                    state_next   = (BAD_N == 1) ? ST_IDLE : ST_SUSPECT;
                end
            end
            default: begin
                if (is_good) begin
                    state_next   = ST_ALIVE;
                    bad_cnt_next = '0;
                end else if (is_bad) begin
                    if (bad_inc == BAD_C) begin
                        state_next   = ST_IDLE;
                        bad_cnt_next = '0;
                    end else begin
                        bad_cnt_next = bad_inc;
                    end
                end
            end
        endcase

        period_valid_next = measure;
        period_next       = measure ? cnt_reg : period_reg;
        fault_next        = is_bad;
        if (is_short)     fault_code_next = 2'b01;
        else if (is_bad)  fault_code_next = 2'b10;
        else              fault_code_next = fault_code_reg;

        if (!enable) begin
            state_next        = ST_IDLE;
            cnt_next          = '0;
            armed_next        = 1'b0;
            good_cnt_next     = '0;
            bad_cnt_next      = '0;
            period_valid_next = 1'b0;
            fault_next        = 1'b0;
            period_next       = period_reg;
            fault_code_next   = fault_code_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg          <= '0;
            armed_reg        <= 1'b0;
            good_cnt_reg     <= '0;
            bad_cnt_reg      <= '0;
            state_reg        <= ST_IDLE;
            period_reg       <= '0;
            period_valid_reg <= 1'b0;
            fault_reg        <= 1'b0;
            fault_code_reg   <= 2'b00;
        end else begin
            cnt_reg          <= cnt_next;
            armed_reg        <= armed_next;
            good_cnt_reg     <= good_cnt_next;
            bad_cnt_reg      <= bad_cnt_next;
            state_reg        <= state_next;
            period_reg       <= period_next;
            period_valid_reg <= period_valid_next;
            fault_reg        <= fault_next;
            fault_code_reg   <= fault_code_next;
        end
    end

    assign io           = (state_reg == ST_ALIVE) || (state_reg == ST_SUSPECT);
    assign state        = state_reg;
    assign period       = period_reg;
    assign period_valid = period_valid_reg;
    assign fault        = fault_reg;
    assign fault_code   = fault_code_reg;

endmodule

// File: tb/tb_heartbeat_window_monitor.sv
// Directed bench for heartbeat_window_monitor with a short 40..60 clk window.
module tb_heartbeat_window_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic        pwm;
    logic        enable;
    logic        io;
    logic [1:0]  state;
    logic [23:0] period;
    logic        period_valid;
    logic        fault;
    logic [1:0]  fault_code;

    int checks   = 0;
    int failures = 0;

    // obs layout: {pv, period[23:0], fault, fault_code, state, io, clean}
    logic [31:0] obs;
    int          extra;

    heartbeat_window_monitor #(
        .CNT_W(24), .MIN_PERIOD(40), .MAX_PERIOD(60), .GOOD_N(4), .BAD_N(2)
    ) dut (
        .clk(clk), .rst(rst), .pwm(pwm), .enable(enable), .io(io),
        .state(state), .period(period), .period_valid(period_valid),
        .fault(fault), .fault_code(fault_code)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got running exp finished");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mk(input logic pv, input int per, input logic f,
                                       input logic [1:0] fc, input logic [1:0] st,
                                       input logic o);
        logic [31:0] v;
        v = {pv, per[23:0], f, fc, st, o, 1'b1};
        return v;
    endfunction

    function automatic string show(input logic [31:0] v);
        return $sformatf("pv=%b per=%0d f=%b fc=%b st=%0d io=%b clean=%b",
                         v[31], v[30:7], v[6], v[5:4], v[3:2], v[1], v[0]);
    endfunction

    // Rise exactly gap clocks after the previous rise; capture the strobe slot
    // 4 clocks after the rise and flag any strobe seen elsewhere.
    task automatic do_rise(input int gap);
        extra = 0;
        for (int c = 1; c <= gap - 4; c++) begin
            @(negedge clk);
            if (period_valid || fault) extra++;
        end
        pwm = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 2) pwm = 1'b0;
            if (c < 4) begin
                if (period_valid || fault) extra++;
            end else begin
                obs = {period_valid, period, fault, fault_code, state, io, 1'b0};
            end
        end
        obs[0] = (extra == 0);
        $display("rise gap=%0d -> %s", gap, show(obs));
    endtask

    task automatic do_reset();
        rst = 1'b1; pwm = 1'b0; enable = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic go_alive();
        logic [31:0] exp_v;
        do_reset();
        do_rise(10);
        repeat (4) do_rise(50);
        exp_v = mk(1, 50, 0, 2'b00, 2'd2, 1);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL go_alive: got %s exp %s", show(obs), show(exp_v));
        end
    endtask

    task automatic test_reset();
        logic [31:0] exp_v;
        rst = 1'b1; pwm = 1'b0; enable = 1'b1;
        repeat (3) @(negedge clk);
        obs = {period_valid, period, fault, fault_code, state, io, 1'b1};
        exp_v = mk(0, 0, 0, 2'b00, 2'd0, 0);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL reset_hold: got %s exp %s", show(obs), show(exp_v));
        end
        rst = 1'b0;
        repeat (5) @(negedge clk);
        obs = {period_valid, period, fault, fault_code, state, io, 1'b1};
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL reset_idle: got %s exp %s", show(obs), show(exp_v));
        end
        $display("reset -> %s", show(obs));
    endtask

    task automatic test_acquire();
        logic [31:0] exp_v;
        do_reset();
        do_rise(20);
        exp_v = mk(0, 0, 0, 2'b00, 2'd1, 0);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL acq_arm: got %s exp %s", show(obs), show(exp_v));
        end
        for (int i = 1; i <= 5; i++) begin
            do_rise(50);
            exp_v = (i >= 4) ? mk(1, 50, 0, 2'b00, 2'd2, 1) : mk(1, 50, 0, 2'b00, 2'd1, 0);
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL acq_meas%0d: got %s exp %s", i, show(obs), show(exp_v));
            end
        end
    endtask

    task automatic test_window();
        int          gaps [4] = '{40, 60, 39, 50};
        logic [31:0] exps [4];
        exps[0] = mk(1, 40, 0, 2'b00, 2'd2, 1);
        exps[1] = mk(1, 60, 0, 2'b00, 2'd2, 1);
        exps[2] = mk(1, 39, 1, 2'b01, 2'd3, 1);
        exps[3] = mk(1, 50, 0, 2'b01, 2'd2, 1);
        for (int i = 0; i < 4; i++) begin
            do_rise(gaps[i]);
            checks++;
            if (obs !== exps[i]) begin
                failures++;
                $display("FAIL window_gap%0d: got %s exp %s", gaps[i], show(obs), show(exps[i]));
            end
        end
    endtask

    task automatic test_timeout();
        logic [31:0] exp_v;
        int          first;
        int          stray;
        first = 0;
        stray = 0;
        obs   = '0;
        for (int c = 1; c <= 100 && first == 0; c++) begin
            @(negedge clk);
            if (fault) begin
                first = c;
                obs = {period_valid, period, fault, fault_code, state, io, (stray == 0)};
            end else if (period_valid) begin
                stray++;
            end
        end
        $display("timeout first_fault=%0d -> %s", first, show(obs));
        checks++;
        if (first !== 61) begin
            failures++;
            $display("FAIL timeout_delay: got %0d exp 61 clk after measure strobe", first);
        end
        exp_v = mk(0, 50, 1, 2'b10, 2'd3, 1);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL timeout_state: got %s exp %s", show(obs), show(exp_v));
        end
        do_rise(20);
        exp_v = mk(0, 50, 0, 2'b10, 2'd3, 1);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL timeout_rearm: got %s exp %s", show(obs), show(exp_v));
        end
        do_rise(30);
        exp_v = mk(1, 30, 1, 2'b01, 2'd0, 0);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL timeout_dead: got %s exp %s", show(obs), show(exp_v));
        end
    endtask

    task automatic test_short_in_acquire();
        logic [31:0] exp_v;
        do_reset();
        do_rise(10);
        repeat (3) do_rise(50);
        exp_v = mk(1, 50, 0, 2'b00, 2'd1, 0);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL acqshort_pre: got %s exp %s", show(obs), show(exp_v));
        end
        do_rise(20);
        exp_v = mk(1, 20, 1, 2'b01, 2'd1, 0);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL acqshort_short: got %s exp %s", show(obs), show(exp_v));
        end
        for (int i = 1; i <= 4; i++) begin
            do_rise(45);
            exp_v = (i == 4) ? mk(1, 45, 0, 2'b01, 2'd2, 1) : mk(1, 45, 0, 2'b01, 2'd1, 0);
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL acqshort_good%0d: got %s exp %s", i, show(obs), show(exp_v));
            end
        end
    endtask

    task automatic test_enable_drop();
        logic [31:0] exp_v;
        go_alive();
        repeat (10) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        checks++;
        if ({state, io, period_valid, fault} !== 5'b0) begin
            failures++;
            $display("FAIL enable_drop: got st=%0d io=%b pv=%b f=%b exp st=0 io=0 pv=0 f=0",
                     state, io, period_valid, fault);
        end
        $display("enable drop -> st=%0d io=%b", state, io);
        enable = 1'b1;
        do_rise(30);
        exp_v = mk(0, 50, 0, 2'b00, 2'd1, 0);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL enable_rearm: got %s exp %s", show(obs), show(exp_v));
        end
        do_rise(50);
        exp_v = mk(1, 50, 0, 2'b00, 2'd1, 0);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL enable_meas: got %s exp %s", show(obs), show(exp_v));
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] exp_v;
        go_alive();
        do_rise(39);
        exp_v = mk(1, 39, 1, 2'b01, 2'd3, 1);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL rstmid_suspect: got %s exp %s", show(obs), show(exp_v));
        end
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        obs = {period_valid, period, fault, fault_code, state, io, 1'b1};
        exp_v = mk(0, 0, 0, 2'b00, 2'd0, 0);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL rstmid_outputs: got %s exp %s", show(obs), show(exp_v));
        end
        rst = 1'b0;
        do_rise(30);
        exp_v = mk(0, 0, 0, 2'b00, 2'd1, 0);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL rstmid_arm: got %s exp %s", show(obs), show(exp_v));
        end
    endtask

    task automatic test_coincident();
        logic [31:0] exp_v;
        int          faults_after;
        go_alive();
        do_rise(61);
        exp_v = mk(1, 61, 1, 2'b10, 2'd3, 1);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL coincident: got %s exp %s", show(obs), show(exp_v));
        end
        faults_after = 0;
        repeat (10) begin
            @(negedge clk);
            if (fault) faults_after++;
        end
        checks++;
        if (faults_after !== 0) begin
            failures++;
            $display("FAIL coincident_single: got %0d extra faults exp 0", faults_after);
        end
    endtask

    initial begin
        rst = 1'b1; pwm = 1'b0; enable = 1'b1;
        test_reset();
        test_acquire();
        test_window();
        test_timeout();
        test_short_in_acquire();
        test_enable_drop();
        test_reset_mid();
        test_coincident();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
